seq_mult: RTL and testbench
===========================

# seq_mult

Parametrised, multi-cycle shift-add multiplier; the sequential successor to the 4-bit combinational multiplier in the integer ALU. Takes two WIDTH-bit operands on a start pulse, computes the full 2·WIDTH-bit product over WIDTH+2 cycles in unsigned or two's-complement mode, and returns it split into low and high halves with a one-cycle done pulse. Sits beside the ALU's combinational 4-bit operations as the multiply path for wider operands, trading latency for area.

## Interface
- WIDTH, 8, operand width in bits; legal values are 2 and up. Product width is 2·WIDTH.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high, one clock.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  0 selects unsigned, 1 selects two's-complement. Sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when out_lo/out_hi become valid.
- out_lo  output  WIDTH  product bits [WIDTH-1:0].
- out_hi  output  WIDTH  product bits [2·WIDTH-1:WIDTH].

## Operation
- States: IDLE, CALC, SIGN.
- IDLE, start=1:
  - Latch signed_mode and the sign flag (a[MSB] XOR b[MSB] when signed, else 0).
  - Latch operand magnitudes (absolute values when signed, raw values otherwise).
  - Clear the 2·WIDTH-bit accumulator and the bit counter; set busy=1; go to CALC.
- IDLE, start=0: hold all state.
- CALC, each cycle:
  - If the current multiplier bit is 1, add the multiplicand, shifted by the bit index, into the accumulator.
  - Advance the counter.
  - After processing bit WIDTH-1, go to SIGN.
  - Use exactly one adder of 2·WIDTH bits (or WIDTH+1 bits with a shifting accumulator). No multiply operator.
- SIGN:
  - Write the accumulator to out_hi:out_lo, two's-complement negated if the sign flag is set.
  - Set done=1, busy=0; go to IDLE.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). This must be handled as an unsigned WIDTH-bit value; no overflow case exists.
- start while busy=1 is ignored, with no effect on the operation in flight. Operand and mode inputs are don't-care after the start cycle.
- out_lo/out_hi hold the last result until the next SIGN cycle; they are not cleared by a new start.
- A zero operand yields a zero product; negative zero never appears.

## Timing
- Reset values: busy=0, done=0, out_lo=0, out_hi=0; state IDLE; accumulator and counter zero.
- rst dominates start and aborts any operation in flight. The next cycle is IDLE with reset values, and no done pulse is produced for the aborted operation.
- Start accepted at edge 0:
  - busy visible high after edge 0.
  - CALC occupies edges 1..WIDTH.
  - SIGN at edge WIDTH+1 sets done=1, busy=0 and valid outputs.
  - done is cleared at edge WIDTH+2.
- Latency from start edge to done: WIDTH+1 cycles.
- Maximum throughput is one operation per WIDTH+2 cycles. start held high continuously is accepted on the cycle done is high, giving back-to-back operation.
- done and busy are never high simultaneously.

## Test plan
- WIDTH=4, unsigned: a=3, b=2 -> out_lo=6, out_hi=0. a=8, b=4 -> lo=0, hi=2. a=7, b=7 -> lo=1, hi=3. a=15, b=15 -> lo=1, hi=14. done rises exactly 5 cycles after each start edge.
- WIDTH=4, signed:
  - -8×-8 -> lo=0, hi=4.
  - -1×7 -> lo=9, hi=15.
  - -8×7 -> lo=8, hi=12.
  - 0×-5 -> lo=0, hi=0.
- WIDTH=8, unsigned 255×255 -> hi=0xFE, lo=0x01. Signed 0x80×0x7F -> 0xC080 (hi=0xC0, lo=0x80). done 9 cycles after start.
- Start while busy: with WIDTH=4, pulse start with different a/b at cycles 2 and 3 of an operation. The result matches the original operands, and only one done pulse occurs.
- Reset mid-operation: assert rst in cycle 3 of CALC. Next cycle shows busy=0, done=0, out_lo=out_hi=0, and no done follows. A fresh start then completes correctly.
- Back-to-back: hold start=1 with a new operand set on each accept. Successive done pulses are spaced WIDTH+2 cycles apart, and each result matches its own operands.

Source files
------------

// File: rtl/seq_mult_if.sv
// Operand/result bundle for seq_mult: the requester drives the start request and
// operands, and the multiplier returns status and the split 2*WIDTH-bit product.
interface seq_mult_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_lo;
    logic [WIDTH-1:0] out_hi;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, out_lo, out_hi
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, out_lo, out_hi
    );
endinterface

// File: rtl/seq_mult.sv
// Multi-cycle shift-add multiplier: multiplies operand magnitudes one multiplier bit
// per cycle, then applies the result sign in a final cycle.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_mult_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   out_lo_q, out_lo_d;
    logic [WIDTH-1:0]   out_hi_q, out_hi_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] product;

    // Magnitudes are kept unsigned, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
        if (bus.signed_mode && bus.a[WIDTH-1]) mag_a = ~bus.a + WIDTH'(1);
        if (bus.signed_mode && bus.b[WIDTH-1]) mag_b = ~bus.b + WIDTH'(1);
    end

    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign product = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Multiplicand shifts left so it is already aligned to the current bit.
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = SIGN;
            end
            SIGN: begin
                {out_hi_d, out_lo_d} = product;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_lo_q <= '0;
            out_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.out_lo = out_lo_q;
    assign bus.out_hi = out_hi_q;
endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=4 and WIDTH=8: stimulus pushes arithmetic
// reference products with their expected done cycle, monitors pop on each done pulse.
module tb_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int lo;
        int hi;
        int cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    seq_mult_if #(.WIDTH(4)) bus4 ();
    seq_mult_if #(.WIDTH(8)) bus8 ();

    seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Full product from signed/unsigned integer arithmetic, truncated to 2*w bits.
    function automatic int refProduct(input int w, input logic sm, input int a, input int b);
        int mask = (1 << w) - 1;
        int av = a & mask;
        int bv = b & mask;
        if (sm && av >= (1 << (w - 1))) av -= (1 << w);
        if (sm && bv >= (1 << (w - 1))) bv -= (1 << w);
        return (av * bv) & ((1 << (2 * w)) - 1);
    endfunction

    // Waits until the selected DUT can accept, raises start, and records the expectation.
    // start is left high; the caller drops it with releaseStart unless it wants back-to-back.
    task automatic applyStimulus(input bit sel8, input logic sm, input int a, input int b);
        int n = 0;
        int w = sel8 ? 8 : 4;
        int p;
        exp_t e;
        @(negedge clk);
        while ((sel8 ? bus8.busy : bus4.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("accept timeout", 1, 0);
        if (sel8) begin
            bus8.a = 8'(a); bus8.b = 8'(b); bus8.signed_mode = sm; bus8.start = 1'b1;
        end else begin
            bus4.a = 4'(a); bus4.b = 4'(b); bus4.signed_mode = sm; bus4.start = 1'b1;
        end
        @(posedge clk);
        #1;
        p = refProduct(w, sm, a, b);
        e.lo  = p & ((1 << w) - 1);
        e.hi  = (p >> w) & ((1 << w) - 1);
        e.cyc = cyc + w + 1;
        if (sel8) q8.push_back(e);
        else q4.push_back(e);
    endtask

    task automatic releaseStart(input bit sel8);
        @(negedge clk);
        if (sel8) bus8.start = 1'b0;
        else bus4.start = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) checkOutput("drain timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor for the 4-bit instance: results, timing, and busy/done exclusivity.
    always @(negedge clk) begin
        exp_t e;
        if (bus4.done) begin
            checkOutput("w4 busy low with done", int'(bus4.busy), 0);
            if (q4.size() == 0) begin
                checkOutput("w4 unexpected done", 1, 0);
            end else begin
                e = q4.pop_front();
                checkOutput("w4 out_lo", int'(bus4.out_lo), e.lo);
                checkOutput("w4 out_hi", int'(bus4.out_hi), e.hi);
                checkOutput("w4 done cycle", cyc, e.cyc);
            end
        end else if (q4.size() != 0 && cyc > q4[0].cyc) begin
            checkOutput("w4 missing done", cyc, q4[0].cyc);
            void'(q4.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus8.done) begin
            checkOutput("w8 busy low with done", int'(bus8.busy), 0);
            if (q8.size() == 0) begin
                checkOutput("w8 unexpected done", 1, 0);
            end else begin
                e = q8.pop_front();
                checkOutput("w8 out_lo", int'(bus8.out_lo), e.lo);
                checkOutput("w8 out_hi", int'(bus8.out_hi), e.hi);
                checkOutput("w8 done cycle", cyc, e.cyc);
            end
        end else if (q8.size() != 0 && cyc > q8[0].cyc) begin
            checkOutput("w8 missing done", cyc, q8[0].cyc);
            void'(q8.pop_front());
        end
    end

    initial begin
        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = '0; bus4.b = '0;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset w4 busy", int'(bus4.busy), 0);
        checkOutput("reset w4 done", int'(bus4.done), 0);
        checkOutput("reset w4 out_lo", int'(bus4.out_lo), 0);
        checkOutput("reset w4 out_hi", int'(bus4.out_hi), 0);
        checkOutput("reset w8 busy", int'(bus8.busy), 0);
        checkOutput("reset w8 out_lo", int'(bus8.out_lo), 0);
        checkOutput("reset w8 out_hi", int'(bus8.out_hi), 0);
        rst = 1'b0;

        $display("[TB] directed unsigned and signed WIDTH=4");
        applyStimulus(0, 0, 3, 2);   releaseStart(0);
        applyStimulus(0, 0, 8, 4);   releaseStart(0);
        applyStimulus(0, 0, 7, 7);   releaseStart(0);
        applyStimulus(0, 0, 15, 15); releaseStart(0);
        applyStimulus(0, 1, 8, 8);   releaseStart(0);
        applyStimulus(0, 1, 15, 7);  releaseStart(0);
        applyStimulus(0, 1, 8, 7);   releaseStart(0);
        applyStimulus(0, 1, 0, 11);  releaseStart(0);

        $display("[TB] directed WIDTH=8");
        applyStimulus(1, 0, 255, 255); releaseStart(1);
        applyStimulus(1, 1, 128, 127); releaseStart(1);
        applyStimulus(1, 1, 128, 128); releaseStart(1);
        waitIdle();

        $display("[TB] start while busy");
        applyStimulus(0, 0, 3, 5);
        @(negedge clk); bus4.start = 1'b0;
        @(negedge clk); bus4.start = 1'b1; bus4.a = 4'd12; bus4.b = 4'd9;
        @(negedge clk); bus4.a = 4'd6; bus4.b = 4'd10;
        @(negedge clk); bus4.start = 1'b0;
        waitIdle();
        waitIdle();

        $display("[TB] reset mid-operation");
        applyStimulus(0, 1, 13, 6);
        @(negedge clk); bus4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        void'(q4.pop_back());
        @(negedge clk);
        checkOutput("abort busy", int'(bus4.busy), 0);
        checkOutput("abort done", int'(bus4.done), 0);
        checkOutput("abort out_lo", int'(bus4.out_lo), 0);
        checkOutput("abort out_hi", int'(bus4.out_hi), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        applyStimulus(0, 1, 9, 3); releaseStart(0);
        waitIdle();

        $display("[TB] back-to-back with start held");
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)));
        releaseStart(0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)));
        releaseStart(1);
        waitIdle();

        $display("[TB] random isolated operations");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)));
            releaseStart(0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)));
            releaseStart(1);
        end
        waitIdle();
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
